// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one load/store at a time, programmable wait states,
// byte-lane stores and range/alignment faults. Define DMEM_ERR_CNT_EN to add err_count.
module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
`ifdef DMEM_ERR_CNT_EN
    output logic        rsp_err,
    output logic [15:0] err_count
`else
    output logic        rsp_err
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] LAT_INIT = 4'(LATENCY);

    if (LATENCY < 0 || LATENCY > 15) begin : g_lat_chk
        $error("dmem_responder: LATENCY must be within 0..15");
    end
    if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_depth_chk
        $error("dmem_responder: DEPTH must be a power of 2 and at least 2");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [3:0]      cnt;
    logic            we_q;
    logic            err_q;
    logic [AW-1:0]   idx_q;
    logic [7:0][7:0] wdata_q;
    logic [7:0]      be_q;
    logic [7:0][7:0] mem [DEPTH];
    logic            req_fire;
    logic            rsp_fire;
    logic            access;

    assign req_fire = req_valid && req_ready;
    assign rsp_fire = rsp_valid && rsp_ready;
    assign access   = (state == S_WAIT) && (cnt == 4'd0);

    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (req_fire)       state_nxt = S_WAIT;
            S_WAIT:  if (cnt == 4'd0)    state_nxt = S_RESP;
            S_RESP:  if (rsp_fire)       state_nxt = S_IDLE;
            default:                     state_nxt = S_IDLE;
        endcase
    end

    // req_ready is gated by reset so nothing is accepted while reset is held
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            S_IDLE:  req_ready = reset;
            S_RESP:  rsp_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (req_fire) begin
            we_q    <= req_we;
            idx_q   <= req_addr[AW+2:3];
            wdata_q <= req_wdata;
            be_q    <= req_be;
            err_q   <= (|req_addr[2:0]) || (|req_addr[63:AW+3]);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt       <= 4'd0;
            rsp_rdata <= 64'd0;
            rsp_err   <= 1'b0;
        end else begin
            if (req_fire)
                cnt <= LAT_INIT;
            else if (state == S_WAIT && cnt != 4'd0)
                cnt <= cnt - 4'd1;
            if (access) begin
                rsp_err   <= err_q;
                rsp_rdata <= (!we_q && !err_q) ? mem[idx_q] : 64'd0;
            end
        end
    end

    // Storage is never reset; a reset at the access edge suppresses the write
    always_ff @(posedge clk) begin
        if (reset && access && we_q && !err_q) begin
            for (int i = 0; i < 8; i++)
                if (be_q[i]) mem[idx_q][i] <= wdata_q[i];
        end
    end

`ifdef DMEM_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (!reset)
            err_count <= 16'd0;
        else if (rsp_fire && rsp_err && err_count != 16'hFFFF)
            err_count <= err_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, hand-written reset/backpressure
// sequences, and randomized traffic against a word-array reference model.
module tb_dmem_responder;

    localparam int DEPTH = 256;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [63:0] req_addr, req_wdata;
    logic [7:0]  req_be;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [63:0] rsp_rdata;
    logic        req_valid0, req_ready0, req_we0;
    logic [63:0] req_addr0, req_wdata0;
    logic [7:0]  req_be0;
    logic        rsp_valid0, rsp_ready0, rsp_err0;
    logic [63:0] rsp_rdata0;
`ifdef DMEM_ERR_CNT_EN
    logic [15:0] err_count, err_count0;
`endif

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
`ifdef DMEM_ERR_CNT_EN
        .rsp_err(rsp_err), .err_count(err_count)
`else
        .rsp_err(rsp_err)
`endif
    );

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(0)) u_dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
        .req_addr(req_addr0), .req_wdata(req_wdata0), .req_be(req_be0),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_rdata(rsp_rdata0),
`ifdef DMEM_ERR_CNT_EN
        .rsp_err(rsp_err0), .err_count(err_count0)
`else
        .rsp_err(rsp_err0)
`endif
    );

    int checks = 0;
    int errors = 0;
    int err_m  = 0;
    logic [63:0] mem_m [DEPTH];

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  be;
        logic [63:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: a plain word array; faults are any misalignment or word index past DEPTH
    task automatic model(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [7:0] be, output logic [63:0] rd, output logic er);
        logic [63:0] w;
        w  = addr >> 3;
        er = (addr[2:0] != 3'd0) || (w >= 64'(DEPTH));
        rd = 64'd0;
        if (!er) begin
            if (we) begin
                for (int i = 0; i < 8; i++)
                    if (be[i]) mem_m[int'(w)][8*i +: 8] = wdata[8*i +: 8];
            end else begin
                rd = mem_m[int'(w)];
            end
        end
    endtask

    task automatic junk_req();
        req_valid = 1'($urandom_range(0, 1));
        req_we    = 1'($urandom_range(0, 1));
        req_addr  = {$urandom, $urandom};
        req_wdata = {$urandom, $urandom};
        req_be    = 8'($urandom);
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again
    task automatic xact(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [7:0] be, input int hold,
                        output logic [63:0] rd, output logic er, output int cyc);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        chk("req_ready_idle", 64'(req_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        cyc = 1;
        while (!rsp_valid && cyc < 40) begin
            chk("req_ready_wait", 64'(req_ready), 64'd0);
            junk_req();
            @(negedge clk);
            cyc++;
        end
        rd = rsp_rdata;
        er = rsp_err;
        for (int h = 0; h < hold; h++) begin
            junk_req();
            @(negedge clk);
            chk("hold_valid", 64'(rsp_valid), 64'd1);
            chk("hold_rdata", rsp_rdata, rd);
            chk("hold_err", 64'(rsp_err), 64'(er));
            chk("hold_req_ready", 64'(req_ready), 64'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_valid_drop", 64'(rsp_valid), 64'd0);
        chk("req_ready_after", 64'(req_ready), 64'd1);
    endtask

    task automatic run(input string name, input logic we, input logic [63:0] addr,
                       input logic [63:0] wdata, input logic [7:0] be, input int hold,
                       input logic use_tbl, input logic [63:0] t_rd, input logic t_er);
        logic [63:0] m_rd, rd;
        logic        m_er, er;
        int          cyc;
        model(we, addr, wdata, be, m_rd, m_er);
        if (use_tbl) begin
            m_rd = t_rd;
            m_er = t_er;
        end
        if (m_er) err_m++;
        xact(we, addr, wdata, be, hold, rd, er, cyc);
        chk({name, "_rdata"}, rd, m_rd);
        chk({name, "_err"}, 64'(er), 64'(m_er));
        chk({name, "_latency"}, 64'(cyc), 64'(LAT + 2));
`ifdef DMEM_ERR_CNT_EN
        chk({name, "_err_count"}, 64'(err_count), 64'(err_m));
`endif
    endtask

    task automatic xact0(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                         output logic [63:0] rd, output int cyc);
        req_valid0 = 1'b1; req_we0 = we; req_addr0 = addr; req_wdata0 = wdata; req_be0 = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        req_valid0 = 1'b0;
        cyc = 1;
        while (!rsp_valid0 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        rd = rsp_rdata0;
        rsp_ready0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready0 = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rd, old20;
        logic        er;
        int          cyc, n;

        tbl[0]  = '{1'b1, 64'h10,  64'h1122334455667788, 8'hFF, 64'h0, 1'b0};
        tbl[1]  = '{1'b0, 64'h10,  64'h0,                8'h00, 64'h1122334455667788, 1'b0};
        tbl[2]  = '{1'b1, 64'h10,  64'hAAAAAAAAAAAAAAAA, 8'h0F, 64'h0, 1'b0};
        tbl[3]  = '{1'b0, 64'h10,  64'h0,                8'hFF, 64'h11223344AAAAAAAA, 1'b0};
        tbl[4]  = '{1'b1, 64'h0,   64'h0123456789ABCDEF, 8'hFF, 64'h0, 1'b0};
        tbl[5]  = '{1'b0, 64'h13,  64'h0,                8'h00, 64'h0, 1'b1};
        tbl[6]  = '{1'b0, 64'h800, 64'h0,                8'h00, 64'h0, 1'b1};
        tbl[7]  = '{1'b1, 64'h800, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 64'h0, 1'b1};
        tbl[8]  = '{1'b0, 64'h0,   64'h0,                8'h00, 64'h0123456789ABCDEF, 1'b0};
        tbl[9]  = '{1'b1, 64'h10,  64'h5555555555555555, 8'h00, 64'h0, 1'b0};
        tbl[10] = '{1'b0, 64'h10,  64'h0,                8'h00, 64'h11223344AAAAAAAA, 1'b0};
        tbl[11] = '{1'b1, 64'h7F8, 64'hCAFEF00DDEADBEEF, 8'hFF, 64'h0, 1'b0};
        tbl[12] = '{1'b0, 64'h7F8, 64'h0,                8'h00, 64'hCAFEF00DDEADBEEF, 1'b0};
        tbl[13] = '{1'b1, 64'h7FC, 64'h0,                8'hFF, 64'h0, 1'b1};

        reset = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        rsp_ready = 1'b0;
        req_valid0 = 1'b0; req_we0 = 1'b0; req_addr0 = '0; req_wdata0 = '0; req_be0 = '0;
        rsp_ready0 = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_req_ready", 64'(req_ready), 64'd0);
        chk("reset_rdata", rsp_rdata, 64'd0);
        chk("reset_err", 64'(rsp_err), 64'd0);
`ifdef DMEM_ERR_CNT_EN
        chk("reset_err_count", 64'(err_count), 64'd0);
`endif
        reset = 1'b1;
        @(negedge clk);
        chk("post_reset_req_ready", 64'(req_ready), 64'd1);

        // Fill every word so later random loads have defined expectations
        for (int w = 0; w < DEPTH; w++)
            run("init", 1'b1, 64'(w) << 3, {$urandom, $urandom}, 8'hFF, 0, 1'b0, 64'd0, 1'b0);

        for (int i = 0; i < 14; i++)
            run($sformatf("tbl%0d", i), tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be,
                i % 2, 1'b1, tbl[i].exp_rd, tbl[i].exp_err);

        // Backpressure: response must hold for 5 cycles with rsp_ready low
        run("hold5", 1'b0, 64'h10, 64'd0, 8'h00, 5, 1'b1, 64'h11223344AAAAAAAA, 1'b0);

        // Reset during the first WAIT cycle abandons the store
        old20 = mem_m[4];
        req_valid = 1'b1; req_we = 1'b1; req_addr = 64'h20; req_wdata = ~old20; req_be = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_wait_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_wait_req_ready", 64'(req_ready), 64'd0);
        reset = 1'b1;
        err_m = 0;
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid) n++;
        end
        chk("rst_wait_no_rsp", 64'(n), 64'd0);
        chk("rst_wait_idle", 64'(req_ready), 64'd1);
`ifdef DMEM_ERR_CNT_EN
        chk("rst_err_count_clear", 64'(err_count), 64'd0);
`endif
        run("load20_after_rst", 1'b0, 64'h20, 64'd0, 8'h00, 0, 1'b1, old20, 1'b0);

        // Reset while in RESP drops the response
        req_valid = 1'b1; req_we = 1'b0; req_addr = 64'h10; req_be = 8'h00;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("rst_resp_seen", 64'(rsp_valid), 64'd1);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_resp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_resp_rdata", rsp_rdata, 64'd0);
        chk("rst_resp_err", 64'(rsp_err), 64'd0);
        reset = 1'b1;
        err_m = 0;
        @(negedge clk);
        chk("rst_resp_idle", 64'(req_ready), 64'd1);
        chk("rst_resp_no_valid", 64'(rsp_valid), 64'd0);

        // Zero wait-state instance
        xact0(1'b1, 64'h18, 64'hDEADBEEF01234567, rd, cyc);
        chk("lat0_store_latency", 64'(cyc), 64'd2);
        xact0(1'b0, 64'h18, 64'd0, rd, cyc);
        chk("lat0_load_latency", 64'(cyc), 64'd2);
        chk("lat0_load_rdata", rd, 64'hDEADBEEF01234567);

        // Randomized traffic
        for (int i = 0; i < 150; i++) begin
            logic [63:0] a;
            int          r;
            r = int'($urandom_range(0, 9));
            a = 64'($urandom_range(0, DEPTH - 1)) << 3;
            if (r == 0)      a = a | 64'($urandom_range(1, 7));
            else if (r == 1) a = {32'($urandom_range(0, 3)), $urandom} | 64'h800;
            run("rand", 1'($urandom_range(0, 1)), a, {$urandom, $urandom}, 8'($urandom),
                int'($urandom_range(0, 2)), 1'b0, 64'd0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the core's data-memory port: accepts one load/store request at a time over a valid/ready request channel and returns the result over a valid/ready response channel.
- Models a multi-cycle data RAM with a programmable wait-state count, byte-lane writes and range/alignment error reporting.
- Sits between the processor's load/store initiator and backing storage; it replaces the zero-latency data memory once the pipelined core is brought up.

Parameters:
- DEPTH, 256, number of 64-bit words stored (power of 2, ≥2).
- LATENCY, 2, wait-state cycles inserted before the access is performed (0..15).

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- req_valid  input  1  initiator presents a request.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  64  byte address.
- req_wdata  input  64  store data.
- req_be  input  8  store byte enables; bit i covers wdata[8i+7:8i].
- rsp_valid  output  1  response available.
- rsp_ready  input  1  initiator accepts the response.
- rsp_rdata  output  64  load data; 0 for stores and errors.
- rsp_err  output  1  request faulted.

Behaviour:
- Reset (reset==0 at a rising edge):
  - State goes to IDLE; rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
  - While reset is low, req_ready is forced to 0.
  - Storage is not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready: capture we/addr/wdata/be, load counter with LATENCY, go to WAIT.
- WAIT:
  - req_ready=0.
  - If counter≠0: decrement.
  - If counter==0: perform the access at this edge and go to RESP.
- Latency: handshake sampled in cycle k gives rsp_valid=1 in cycle k+LATENCY+2.
  - LATENCY=0 → k+2.
  - Default LATENCY=2 → k+4.
- Access rules:
  - Word index is addr[ADDR_IDX_W+2:3], where ADDR_IDX_W=$clog2(DEPTH).
  - Error when addr[2:0]≠0 or addr[63:3]≥DEPTH.
  - On error: no storage write, rsp_rdata=0, rsp_err=1.
  - Store: update only the byte lanes with be[i]=1. be=0 is legal and writes nothing. rsp_rdata=0, rsp_err=0.
  - Load: rsp_rdata is the full word (be ignored), rsp_err=0.
- RESP:
  - rsp_valid=1 and req_ready=0.
  - rsp_rdata and rsp_err are held stable until rsp_valid&rsp_ready.
  - On that handshake: rsp_valid=0 and go to IDLE. req_ready=1 in the following cycle; there is no same-cycle request acceptance in RESP.
- Back-to-back store then load to the same word: the load returns the merged (updated) data.
- req_* inputs are ignored outside IDLE.
- rsp_ready is ignored unless rsp_valid=1.
- Reset mid-operation:
  - In WAIT before the access edge: the transaction is abandoned and no write occurs.
  - In RESP: the response is dropped.
  - Either way, IDLE next cycle.
- Counter width is 4 bits; LATENCY outside 0..15 is a compile-time error.

Optional Feature:
- Macro DMEM_ERR_CNT_EN.
- Defined:
  - Adds output err_count[15:0].
  - Increments by 1 at the edge where a faulted request's response handshakes (rsp_valid&rsp_ready&rsp_err).
  - Saturates at 16'hFFFF.
  - Cleared by reset.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Store 64'h1122334455667788 to addr 0x10 with be=8'hFF, then load 0x10 → load rsp_rdata=64'h1122334455667788, rsp_err=0; each rsp_valid rises exactly 4 cycles after its request handshake (LATENCY=2).
- Store 64'hAAAA…AA with be=8'h0F over the previous word at 0x10, then load → rsp_rdata=64'h11223344AAAAAAAA.
- Load addr 0x13 (misaligned) and addr 0x800 (DEPTH=256) → rsp_err=1, rsp_rdata=0 for both. A store to 0x800 leaves every word unchanged. With DMEM_ERR_CNT_EN, err_count=2 after the two loads.
- Hold rsp_ready=0 for 5 cycles after a load response appears → rsp_valid, rsp_rdata and rsp_err stay constant and req_ready=0 throughout. Raise rsp_ready → req_ready=1 the next cycle.
- Issue a store to 0x20, then pull reset low in the first WAIT cycle → rsp_valid never asserts. After release, a load of 0x20 returns the pre-store contents.
- LATENCY=0 build: request handshake in cycle k → rsp_valid in cycle k+2.
